// File: rtl/attribute_emitter_pkg.sv
// Shared constants, attribute type codes, emitter FSM states and the attribute name ROM.
package attribute_emitter_pkg;

  localparam int CHAR_BITES           = 8;
  localparam int ATTRIBUTE_TYPE_BITES = 4;
  localparam int ATT_NAME_MAX_LEN     = 10;
  localparam int NAME_IDX_BITS        = 4;

  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_NONE     = 4'd0;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_COLOR    = 4'd1;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_SIZE     = 4'd2;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_WIDTH    = 4'd3;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_HEIGHT   = 4'd4;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_SRC      = 4'd5;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_HREF     = 4'd6;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_BG       = 4'd7;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_PADDING  = 4'd8;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_MARGIN   = 4'd9;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_BORDER   = 4'd10;
  localparam logic [ATTRIBUTE_TYPE_BITES-1:0] ATT_POSITION = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NAME,
    ST_EQ,
    ST_QOPEN,
    ST_WAIT_DIGITS,
    ST_DIGITS,
    ST_QCLOSE,
    ST_DONE
  } emit_state_t;

  // Name length in characters; zero marks an unsupported type.
  function automatic logic [NAME_IDX_BITS-1:0] att_name_len(input logic [ATTRIBUTE_TYPE_BITES-1:0] t);
    logic [NAME_IDX_BITS-1:0] len;
    case (t)
      ATT_COLOR:    len = 4'd5;
      ATT_SIZE:     len = 4'd4;
      ATT_WIDTH:    len = 4'd5;
      ATT_HEIGHT:   len = 4'd6;
      ATT_SRC:      len = 4'd3;
      ATT_HREF:     len = 4'd4;
      ATT_BG:       len = 4'd10;
      ATT_PADDING:  len = 4'd7;
      ATT_MARGIN:   len = 4'd6;
      ATT_BORDER:   len = 4'd6;
      ATT_POSITION: len = 4'd8;
      default:      len = '0;
    endcase
    return len;
  endfunction

  function automatic logic [8*ATT_NAME_MAX_LEN-1:0] att_name_str(input logic [ATTRIBUTE_TYPE_BITES-1:0] t);
    logic [8*ATT_NAME_MAX_LEN-1:0] s;
    case (t)
      ATT_COLOR:    s = 80'("color");
      ATT_SIZE:     s = 80'("size");
      ATT_WIDTH:    s = 80'("width");
      ATT_HEIGHT:   s = 80'("height");
      ATT_SRC:      s = 80'("src");
      ATT_HREF:     s = 80'("href");
      ATT_BG:       s = 80'("background");
      ATT_PADDING:  s = 80'("padding");
      ATT_MARGIN:   s = 80'("margin");
      ATT_BORDER:   s = 80'("border");
      ATT_POSITION: s = 80'("position");
      default:      s = '0;
    endcase
    return s;
  endfunction

  // Strings are right-aligned, so character idx sits at byte (len-1-idx).
  function automatic logic [CHAR_BITES-1:0] att_name_char(input logic [ATTRIBUTE_TYPE_BITES-1:0] t,
                                                          input logic [NAME_IDX_BITS-1:0] idx);
    logic [8*ATT_NAME_MAX_LEN-1:0] s;
    logic [NAME_IDX_BITS-1:0]      pos;
    logic [CHAR_BITES-1:0]         c;
    s   = att_name_str(t);
    pos = att_name_len(t) - idx - 4'd1;
    c   = '0;
    for (int unsigned i = 0; i < ATT_NAME_MAX_LEN; i++) begin
      if (NAME_IDX_BITS'(i) == pos) c = s[i*8 +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/attribute_emitter_integer_emitter.sv
// Double-dabble binary-to-BCD converter with an ASCII digit-pop interface,
// most significant digit first, leading zeros suppressed.
module integer_emitter
  import attribute_emitter_pkg::*;
#(
  parameter int VAL_WIDTH  = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [VAL_WIDTH-1:0]  value_i,
  input  logic                  pop_i,
  output logic                  digit_valid_o,
  output logic [CHAR_BITES-1:0] digit_o
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(VAL_WIDTH + 1);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  logic [VAL_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [DIG_W-1:0]     rem_q, rem_d, sig_digits;
  logic [3:0]           cur_digit;

  always_comb begin
    bcd_adj    = bcd_q;
    sig_digits = DIG_W'(1);
    cur_digit  = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      if (bcd_q[4*i +: 4] != 4'd0) sig_digits = DIG_W'(i + 1);
      if (DIG_W'(i) == rem_q - DIG_W'(1)) cur_digit = bcd_q[4*i +: 4];
    end
  end

  // VAL_WIDTH shift cycles, then one cycle to count significant digits.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rem_d  = rem_q;
    if (start_i) begin
      bin_d  = value_i;
      bcd_d  = '0;
      cnt_d  = CNT_W'(VAL_WIDTH);
      busy_d = 1'b1;
      rem_d  = '0;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VAL_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
        rem_d  = sig_digits;
      end
    end else if (pop_i && rem_q != '0) begin
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rem_q  <= '0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rem_q  <= rem_d;
    end
  end

  assign digit_valid_o = !busy_q && (rem_q != '0);
  assign digit_o       = {4'h3, cur_digit};

endmodule

// File: rtl/attribute_emitter.sv
// Serializes an (attribute type, value) pair as name=value ASCII text.
// Macro ATTR_EMIT_QUOTES_EN wraps the value in double quotes.
module attribute_emitter
  import attribute_emitter_pkg::*;
#(
  parameter int VAL_WIDTH  = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ATTRIBUTE_TYPE_BITES-1:0] in_type,
  input  logic [VAL_WIDTH-1:0]            in_value,
  output logic [CHAR_BITES-1:0]           out_char,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done,
  output logic                            err
);

  emit_state_t                     state_q;
  logic [ATTRIBUTE_TYPE_BITES-1:0] type_q;
  logic [NAME_IDX_BITS-1:0]        idx_q;
  logic [CHAR_BITES-1:0]           out_char_q;
  logic                            out_valid_q, done_q, err_q;
  logic                            accept, hdr_done, dig_valid, dig_pop;
  logic [CHAR_BITES-1:0]           dig_char;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  integer_emitter #(
    .VAL_WIDTH  (VAL_WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_int (
    .clk_i         (clock),
    .rst_i         (reset),
    .start_i       (accept),
    .value_i       (in_value),
    .pop_i         (dig_pop),
    .digit_valid_o (dig_valid),
    .digit_o       (dig_char)
  );

  // Every path into DIGITS/WAIT_DIGITS is folded into hdr_done/dig_pop so the
  // digit pop and the character load share one condition.
  always_comb begin
    hdr_done = 1'b0;
`ifdef ATTR_EMIT_QUOTES_EN
    hdr_done = (state_q == ST_QOPEN) && out_ready;
`else
    hdr_done = (state_q == ST_EQ) && out_ready;
`endif
    dig_pop = dig_valid && (hdr_done || (state_q == ST_WAIT_DIGITS) ||
                            ((state_q == ST_DIGITS) && out_ready));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      type_q      <= '0;
      idx_q       <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (dig_pop) begin
        state_q     <= ST_DIGITS;
        out_char_q  <= dig_char;
        out_valid_q <= 1'b1;
      end else if (hdr_done) begin
        state_q     <= ST_WAIT_DIGITS;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_valid) begin
              type_q <= in_type;
              if (att_name_len(in_type) == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end else begin
                state_q     <= ST_NAME;
                out_char_q  <= att_name_char(in_type, '0);
                out_valid_q <= 1'b1;
                idx_q       <= 4'd1;
              end
            end
          end
          ST_NAME: begin
            if (out_ready) begin
              if (idx_q == att_name_len(type_q)) begin
                state_q    <= ST_EQ;
                out_char_q <= 8'h3D;
              end else begin
                out_char_q <= att_name_char(type_q, idx_q);
                idx_q      <= idx_q + 1'b1;
              end
            end
          end
`ifdef ATTR_EMIT_QUOTES_EN
          ST_EQ: begin
            if (out_ready) begin
              state_q    <= ST_QOPEN;
              out_char_q <= 8'h22;
            end
          end
          ST_DIGITS: begin
            if (out_ready) begin
              state_q    <= ST_QCLOSE;
              out_char_q <= 8'h22;
            end
          end
          ST_QCLOSE: begin
            if (out_ready) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
`else
          ST_DIGITS: begin
            if (out_ready) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
`endif
          ST_DONE: state_q <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_attribute_emitter.sv
// Scoreboard bench for attribute_emitter: string-level reference model feeds
// expected characters/errors to a queue checked by an independent monitor.
module tb_attribute_emitter;
  import attribute_emitter_pkg::*;

  logic                            clock = 1'b0;
  logic                            reset = 1'b1;
  logic                            in_valid = 1'b0;
  logic                            in_ready;
  logic [ATTRIBUTE_TYPE_BITES-1:0] in_type = '0;
  logic [31:0]                     in_value = '0;
  logic [CHAR_BITES-1:0]           out_char;
  logic                            out_valid;
  logic                            out_ready = 1'b1;
  logic                            done;
  logic                            err;

  attribute_emitter #(.VAL_WIDTH(32), .MAX_DIGITS(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_value  (in_value),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  bit         err_exp_q[$];
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  int         stall_cycles = 0;
  bit         rand_ready = 1'b0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_char = '0;
  string      names[16];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic string model(input logic [3:0] t, input logic [31:0] v);
    string q;
    q = "";
    if (names[t].len() == 0) return "";
`ifdef ATTR_EMIT_QUOTES_EN
    q = "\"";
`endif
    return {names[t], "=", q, $sformatf("%0d", v), q};
  endfunction

  always @(posedge clock) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clock) begin
    logic [7:0] e;
    bit         ee;
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        check(out_valid && out_char == stall_char, "hold_stable", {out_valid, out_char}, {1'b1, stall_char});
      stall_pend = out_valid && !out_ready;
      stall_char = out_char;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check(1'b0, "extra_char", out_char, 0);
        else begin
          e = exp_q.pop_front();
          check(out_char == e, "char", out_char, e);
        end
        xfer_cnt++;
      end
      if (!in_ready && !out_valid && !done) stall_cycles++;
      if (done) begin
        if (err_exp_q.size() == 0) check(1'b0, "spurious_done", 1, 0);
        else begin
          ee = err_exp_q.pop_front();
          check(err == ee, "err", err, ee);
          check(exp_q.size() == 0, "chars_left_at_done", exp_q.size(), 0);
        end
        done_cnt++;
      end
    end
  end

  // Presents a request, waits for acceptance, queues the model's expectation.
  task automatic accept(input logic [3:0] t, input logic [31:0] v, output bit ok, output string s);
    s = model(t, v);
    in_type  = t;
    in_value = v;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check(1'b0, "accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    err_exp_q.push_back(s.len() == 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    stall_cycles = 0;
  endtask

  task automatic do_req(input logic [3:0] t, input logic [31:0] v, input bit poke, input bit chk_stall);
    bit    ok;
    bit    got;
    int    base;
    string s;
    base = done_cnt;
    accept(t, v, ok, s);
    if (!ok) return;
    if (s.len() != 0) check(out_valid && out_char == s[0], "first_char", {out_valid, out_char}, {1'b1, s[0]});
    else check(done && err, "unsupported_done_err", {done, err}, 2'b11);
    if (poke && s.len() != 0) begin
      repeat (4) @(posedge clock);
      #1;
      in_type  = ATT_COLOR;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt > base) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    if (!got) check(1'b0, "done_timeout", 0, 1);
    if (chk_stall) check(stall_cycles > 0, "wait_digits_stall", stall_cycles, 1);
  endtask

  task automatic reset_abort_test();
    bit    ok;
    bit    got;
    int    base_x;
    int    base_d;
    string s;
    base_x = xfer_cnt;
    accept(ATT_PADDING, $urandom, ok, s);
    if (!ok) return;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (xfer_cnt >= base_x + 3) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    if (!got) check(1'b0, "abort_xfer_timeout", xfer_cnt - base_x, 3);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check(!out_valid, "valid_drop_on_reset", out_valid, 0);
    check(in_ready, "idle_on_reset", in_ready, 1);
    exp_q.delete();
    err_exp_q.delete();
    base_d = done_cnt;
    repeat (3) @(posedge clock);
    #1;
    check(!done, "no_done_in_reset", done, 0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check(done_cnt == base_d, "no_done_after_abort", done_cnt - base_d, 0);
  endtask

  initial begin
    names[1]  = "color";
    names[2]  = "size";
    names[3]  = "width";
    names[4]  = "height";
    names[5]  = "src";
    names[6]  = "href";
    names[7]  = "background";
    names[8]  = "padding";
    names[9]  = "margin";
    names[10] = "border";
    names[11] = "position";

    repeat (3) @(posedge clock);
    #1;
    check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    check(out_char == 8'h00, "reset_out_char", out_char, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(err == 1'b0, "reset_err", err, 0);
    check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clock);
    #1;

    rand_ready = 1'b0;
    do_req(ATT_WIDTH, 32'd120, 1'b0, 1'b0);
    do_req(ATT_HEIGHT, 32'd0, 1'b0, 1'b0);
    rand_ready = 1'b1;
    do_req(ATT_BG, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rand_ready = 1'b0;
    do_req(ATT_SRC, 32'd5, 1'b0, 1'b1);
    do_req(4'd0, 32'd123, 1'b0, 1'b0);
    do_req(ATT_MARGIN, 32'd77, 1'b1, 1'b0);
    reset_abort_test();
    do_req(ATT_SIZE, 32'd7, 1'b0, 1'b0);
    do_req(ATT_POSITION, 32'd1_000_000_000, 1'b0, 1'b0);
    do_req(4'd15, 32'd9, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      logic [3:0]  t;
      logic [31:0] v;
      t = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 9));
        2:       v = 32'($urandom_range(0, 99999));
        default: v = 32'hFFFF_FFFF;
      endcase
      rand_ready = 1'($urandom_range(0, 1));
      do_req(t, v, 1'b0, 1'b0);
    end

    rand_ready = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check(exp_q.size() == 0 && err_exp_q.size() == 0, "queues_drained", exp_q.size() + err_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_total);
    $fatal(1, "timeout");
  end

endmodule
